aux_perf_counter_bank: RTL and testbench

Parametrised bank of event counters. It replaces the fixed set of single-purpose 32-bit counters beside the core (cycle, jump, branch, branch-taken) with one block. It adds run control (clear/freeze), atomic snapshot of all channels, a selectable wrap or saturate mode, sticky overflow flags, and a registered read port that feeds the seven-segment display mux. It sits in the board top level on the board clock and counts single-cycle event strobes qualified by the core enable.

---
 rtl/aux_perf_counter_bank.sv | 115 +++++++++++
 tb/tb_aux_perf_counter_bank.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aux_perf_counter_bank.sv
// Purpose : bank of NumCh event counters with run control, atomic snapshot and a registered read port.
// Latency : events land in the live counters at the accepting edge; the read port adds one register stage.
// Backpressure: none; every control input is level-sampled each cycle and events are never stalled.
//
// Ports:
//   clk, rst_n         board clock, asynchronous active-low reset
//   evt[NumCh]         single-cycle event strobes, one per channel
//   clear              synchronous clear of live counters, overflow flags and snap_valid
//   freeze             drops events and holds live counters while high
//   snap               copies every live counter into the shadow bank (pre-update values)
//   rd_sel, rd_src     read channel select; rd_src picks shadow (1) or live (0)
//   rd_data, rd_ovf    registered read data and sticky overflow of the selected channel
//   ovf[NumCh]         sticky overflow flags, all channels
//   snap_valid         a snapshot has been taken since the last reset or clear
module aux_perf_counter_bank #(
    parameter int NumCh    = 4,
    parameter int CntBit   = 32,
    parameter int Saturate = 0,
    parameter int SelBit   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NumCh-1:0]  evt,
    input  logic              clear,
    input  logic              freeze,
    input  logic              snap,
    input  logic [SelBit-1:0] rd_sel,
    input  logic              rd_src,
    output logic [CntBit-1:0] rd_data,
    output logic              rd_ovf,
    output logic [NumCh-1:0]  ovf,
    output logic              snap_valid
);

    localparam logic [CntBit-1:0] CntMax = '1;

    logic [CntBit-1:0] live_q   [NumCh];
    logic [CntBit-1:0] shadow_q [NumCh];

    // Next-state of each live counter and its overflow flag.
    logic [CntBit-1:0] live_nxt [NumCh];
    logic [NumCh-1:0]  ovf_nxt;

    always_comb begin
        ovf_nxt = ovf;
        for (int i = 0; i < NumCh; i++) begin
            live_nxt[i] = live_q[i];
            if (clear) begin
                // Clear outranks freeze and events; the event of this cycle is lost.
                live_nxt[i] = '0;
                ovf_nxt[i]  = 1'b0;
            end else if (!freeze && evt[i]) begin
                if (live_q[i] == CntMax) begin
                    ovf_nxt[i]  = 1'b1;
                    live_nxt[i] = (Saturate != 0) ? CntMax : '0;
                end else begin
                    live_nxt[i] = live_q[i] + CntBit'(1);
                end
            end
        end
    end

    // Counter, shadow and flag state. The shadow copy uses live_q (pre-update),
    // so a snap coincident with clear or an event captures the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumCh; i++) begin
                live_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
            ovf        <= '0;
            snap_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NumCh; i++) begin
                live_q[i] <= live_nxt[i];
                if (snap) begin
                    shadow_q[i] <= live_q[i];
                end
            end
            ovf <= ovf_nxt;
            // snap wins over clear so a snap+clear cycle leaves a valid snapshot.
            if (snap) begin
                snap_valid <= 1'b1;
            end else if (clear) begin
                snap_valid <= 1'b0;
            end
        end
    end

    // Read mux: an out-of-range select matches no channel and reads as zero.
    logic [CntBit-1:0] rd_data_nxt;
    logic              rd_ovf_nxt;

    always_comb begin
        rd_data_nxt = '0;
        rd_ovf_nxt  = 1'b0;
        for (int i = 0; i < NumCh; i++) begin
            if (rd_sel == SelBit'(i)) begin
                rd_data_nxt = rd_src ? shadow_q[i] : live_q[i];
                rd_ovf_nxt  = ovf[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_ovf  <= 1'b0;
        end else begin
            rd_data <= rd_data_nxt;
            rd_ovf  <= rd_ovf_nxt;
        end
    end

endmodule

// File: tb/tb_aux_perf_counter_bank.sv
// Purpose : directed self-checking bench for aux_perf_counter_bank (8-bit wrap, 4-bit wrap, 4-bit saturate).
// Latency : inputs driven and outputs sampled 1 time unit after each rising clk edge.
// Backpressure: not applicable; stimulus is a fixed directed sequence.
module tb_aux_perf_counter_bank;

    logic       clk;
    logic       rst_n;
    logic [3:0] evt;
    logic       clear;
    logic       freeze;
    logic       snap;
    logic [3:0] rd_sel;
    logic       rd_src;

    logic [7:0] rd_data8;
    logic       rd_ovf8;
    logic [3:0] ovf8;
    logic       snap_valid8;

    logic [3:0] rd_data4w;
    logic       rd_ovf4w;
    logic [3:0] ovf4w;
    logic       snap_valid4w;

    logic [3:0] rd_data4s;
    logic       rd_ovf4s;
    logic [3:0] ovf4s;
    logic       snap_valid4s;

    int n_checks = 0;
    int n_fail   = 0;

    aux_perf_counter_bank #(.NumCh(4), .CntBit(8), .Saturate(0), .SelBit(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .evt(evt), .clear(clear), .freeze(freeze), .snap(snap),
        .rd_sel(rd_sel), .rd_src(rd_src), .rd_data(rd_data8), .rd_ovf(rd_ovf8),
        .ovf(ovf8), .snap_valid(snap_valid8)
    );

    aux_perf_counter_bank #(.NumCh(4), .CntBit(4), .Saturate(0), .SelBit(4)) dut4w (
        .clk(clk), .rst_n(rst_n), .evt(evt), .clear(clear), .freeze(freeze), .snap(snap),
        .rd_sel(rd_sel), .rd_src(rd_src), .rd_data(rd_data4w), .rd_ovf(rd_ovf4w),
        .ovf(ovf4w), .snap_valid(snap_valid4w)
    );

    aux_perf_counter_bank #(.NumCh(4), .CntBit(4), .Saturate(1), .SelBit(4)) dut4s (
        .clk(clk), .rst_n(rst_n), .evt(evt), .clear(clear), .freeze(freeze), .snap(snap),
        .rd_sel(rd_sel), .rd_src(rd_src), .rd_data(rd_data4s), .rd_ovf(rd_ovf4s),
        .ovf(ovf4s), .snap_valid(snap_valid4s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One edge with the new select; afterwards rd_* holds the state seen before that edge.
    task automatic read_ch(input int sel, input logic src);
        rd_sel = 4'(sel);
        rd_src = src;
        tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    int         sels  [5] = '{0, 1, 2, 3, 5};
    logic [7:0] exp_d [5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0};
    logic       exp_o [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst_n  = 1'b0;
        evt    = '0;
        clear  = 1'b0;
        freeze = 1'b0;
        snap   = 1'b0;
        rd_sel = 4'd2;
        rd_src = 1'b0;

        // Events during reset are ignored.
        repeat (2) tick();
        evt = 4'b1111;
        repeat (5) tick();
        check("rst_rd_data", rd_data8, 0);
        check("rst_rd_ovf", rd_ovf8, 0);
        check("rst_ovf", ovf8, 0);
        check("rst_snap_valid", snap_valid8, 0);

        // Basic count on channel 2.
        evt   = '0;
        rst_n = 1'b1;
        evt   = 4'b0100;
        repeat (5) tick();
        evt = '0;
        tick();
        check("cnt_ch2", rd_data8, 5);
        read_ch(0, 0); check("cnt_ch0_zero", rd_data8, 0);
        read_ch(1, 0); check("cnt_ch1_zero", rd_data8, 0);
        read_ch(3, 0); check("cnt_ch3_zero", rd_data8, 0);

        // Wrap vs saturate: 17 events on channel 0.
        pulse_clear();
        evt = 4'b0001;
        repeat (17) tick();
        evt = '0;
        read_ch(0, 0);
        check("wrap_live", rd_data4w, 1);
        check("wrap_rd_ovf", rd_ovf4w, 1);
        check("wrap_ovf", ovf4w, 4'b0001);
        check("sat_live", rd_data4s, 15);
        check("sat_rd_ovf", rd_ovf4s, 1);
        check("sat_ovf", ovf4s, 4'b0001);
        check("wide_live", rd_data8, 17);
        check("wide_ovf", ovf8, 0);
        pulse_clear();
        read_ch(0, 0);
        check("wrap_clr_live", rd_data4w, 0);
        check("wrap_clr_ovf", ovf4w, 0);
        check("sat_clr_live", rd_data4s, 0);
        check("sat_clr_ovf", rd_ovf4s, 0);

        // Freeze and clear priority on channel 1.
        evt = 4'b0010;
        repeat (3) tick();
        evt = '0;
        read_ch(1, 0); check("frz_pre", rd_data8, 3);
        freeze = 1'b1;
        evt    = 4'b0010;
        repeat (4) tick();
        evt = '0;
        read_ch(1, 0); check("frz_hold", rd_data8, 3);
        clear = 1'b1;
        evt   = 4'b0010;
        tick();
        clear  = 1'b0;
        freeze = 1'b0;
        evt    = '0;
        read_ch(1, 0); check("frz_clear", rd_data8, 0);
        evt = 4'b0010;
        tick();
        evt = '0;
        read_ch(1, 0); check("frz_after", rd_data8, 1);

        // Snapshot atomicity with coincident clear.
        pulse_clear();
        evt = 4'b1001;
        repeat (2) tick();
        evt = 4'b0001;
        repeat (5) tick();
        evt   = '0;
        snap  = 1'b1;
        clear = 1'b1;
        tick();
        snap  = 1'b0;
        clear = 1'b0;
        check("snapclr_valid", snap_valid8, 1);
        read_ch(0, 1); check("snap_sh0", rd_data8, 7);
        read_ch(3, 1); check("snap_sh3", rd_data8, 2);
        read_ch(0, 0); check("snap_live0", rd_data8, 0);
        read_ch(3, 0); check("snap_live3", rd_data8, 0);
        pulse_clear();
        check("clr_valid", snap_valid8, 0);
        read_ch(0, 1); check("clr_sh0_kept", rd_data8, 7);

        // Snap with a coincident event captures the pre-increment value.
        evt = 4'b0001;
        repeat (2) tick();
        snap = 1'b1;
        tick();
        snap = 1'b0;
        evt  = '0;
        check("snapevt_valid", snap_valid8, 1);
        read_ch(0, 1); check("snapevt_sh0", rd_data8, 2);
        read_ch(0, 0); check("snapevt_live0", rd_data8, 3);

        // Snap honoured under freeze; the event is dropped.
        freeze = 1'b1;
        snap   = 1'b1;
        evt    = 4'b0001;
        tick();
        freeze = 1'b0;
        snap   = 1'b0;
        evt    = '0;
        read_ch(0, 1); check("snapfrz_sh0", rd_data8, 3);
        read_ch(0, 0); check("snapfrz_live0", rd_data8, 3);

        // All channels every cycle: 100 then 256 events.
        pulse_clear();
        evt = 4'b1111;
        repeat (100) tick();
        evt = '0;
        for (int c = 0; c < 4; c++) begin
            read_ch(c, 0);
            check($sformatf("sim100_ch%0d", c), rd_data8, 100);
        end
        check("sim100_ovf", ovf8, 0);
        evt = 4'b1111;
        repeat (156) tick();
        evt = '0;
        check("sim256_ovf", ovf8, 4'b1111);
        for (int c = 0; c < 4; c++) begin
            read_ch(c, 0);
            check($sformatf("sim256_ch%0d", c), rd_data8, 0);
        end

        // Read port: distinct values, overflow flags still set from the wrap above.
        evt = 4'b1111; tick();
        evt = 4'b1110; tick();
        evt = 4'b1100; tick();
        evt = 4'b1000; tick();
        evt = '0;
        for (int k = 0; k < 5; k++) begin
            rd_sel = 4'(sels[k]);
            rd_src = 1'b0;
            #1;
            if (k > 0) check($sformatf("rd_lag_sel%0d", sels[k]), rd_data8, exp_d[k-1]);
            #1;
            @(posedge clk);
            #1;
            check($sformatf("rd_data_sel%0d", sels[k]), rd_data8, exp_d[k]);
            check($sformatf("rd_ovf_sel%0d", sels[k]), rd_ovf8, exp_o[k]);
        end

        // Asynchronous reset mid-cycle clears everything without an edge.
        read_ch(3, 0);
        check("pre_arst_data", rd_data8, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rd_data", rd_data8, 0);
        check("arst_rd_ovf", rd_ovf8, 0);
        check("arst_ovf", ovf8, 0);
        check("arst_snap_valid", snap_valid8, 0);
        read_ch(3, 0);
        check("arst_hold", rd_data8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
